frogger_matrix_scan: RTL and testbench

- Display-side reader of the frogger game state.
- Takes the 8 car-row bitmaps, the frog position and the dead/win flags, and time-multiplexes them onto an 8x8 LED matrix, one row at a time.
- Snapshots all game inputs once per frame to prevent tearing. Adds anti-ghosting blanking, a blinking frog overlay, and dead/win visual effects.

---
 rtl/frogger_matrix_scan.sv | 140 ++++++++++++++
 tb/tb_frogger_matrix_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/frogger_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver for the frogger game state.
// Game inputs are snapshotted at each frame start so that a frame never tears.
module frogger_matrix_scan #(
  parameter int unsigned DWELL_CYCLES = 12500,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] rows_i,
  input  logic [2:0]  frog_row_i,
  input  logic [7:0]  frog_col_i,
  input  logic        dead_i,
  input  logic        win_i,
  output logic [7:0]  row_sel_o,
  output logic [7:0]  col_data_o,
  output logic        frame_start_o
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // row_q/cnt_q name the slot position that the next edge will put on the outputs
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic             blink_q, blink_d;

  logic [63:0]      snap_rows_q, snap_rows_d;
  logic [2:0]       snap_frog_row_q, snap_frog_row_d;
  logic [7:0]       snap_frog_col_q, snap_frog_col_d;
  logic             snap_dead_q, snap_dead_d;
  logic             snap_win_q, snap_win_d;

  logic [7:0]       row_sel_q, row_sel_d;
  logic [7:0]       col_data_q, col_data_d;
  logic             frame_start_q, frame_start_d;

  logic             slot_end_c;
  logic             frame_begin_c;
  logic [7:0]       pix_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q           <= 3'd0;
      cnt_q           <= '0;
      frame_q         <= '0;
      blink_q         <= 1'b1;
      snap_rows_q     <= 64'd0;
      snap_frog_row_q <= 3'd0;
      snap_frog_col_q <= 8'h00;
      snap_dead_q     <= 1'b0;
      snap_win_q      <= 1'b0;
      row_sel_q       <= 8'hFF;
      col_data_q      <= 8'h00;
      frame_start_q   <= 1'b0;
    end else begin
      row_q           <= row_d;
      cnt_q           <= cnt_d;
      frame_q         <= frame_d;
      blink_q         <= blink_d;
      snap_rows_q     <= snap_rows_d;
      snap_frog_row_q <= snap_frog_row_d;
      snap_frog_col_q <= snap_frog_col_d;
      snap_dead_q     <= snap_dead_d;
      snap_win_q      <= snap_win_d;
      row_sel_q       <= row_sel_d;
      col_data_q      <= col_data_d;
      frame_start_q   <= frame_start_d;
    end
  end

  // Pixel rule for the row being driven, evaluated only from the frame snapshot.
  always_comb begin
    pix_c = 8'h00;
    if (snap_dead_q && !blink_q) begin
      pix_c = 8'hFF;
    end else if (snap_win_q && (row_q == 3'd0)) begin
      pix_c = 8'hFF;
    end else begin
      pix_c = snap_rows_q[{row_q, 3'b000} +: 8];
      if ((snap_frog_row_q == row_q) && blink_q) begin
        pix_c = pix_c | snap_frog_col_q;
      end
    end
  end

  always_comb begin
    row_d           = row_q;
    cnt_d           = cnt_q;
    frame_d         = frame_q;
    blink_d         = blink_q;
    snap_rows_d     = snap_rows_q;
    snap_frog_row_d = snap_frog_row_q;
    snap_frog_col_d = snap_frog_col_q;
    snap_dead_d     = snap_dead_q;
    snap_win_d      = snap_win_q;
    row_sel_d       = 8'hFF;
    col_data_d      = 8'h00;
    frame_start_d   = 1'b0;

    slot_end_c    = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    frame_begin_c = (row_q == 3'd0) && (cnt_q == '0);

    if (frame_begin_c) begin
      snap_rows_d     = rows_i;
      snap_frog_row_d = frog_row_i;
      snap_frog_col_d = frog_col_i;
      snap_dead_d     = dead_i;
      snap_win_d      = win_i;
      frame_start_d   = 1'b1;
    end

    if (slot_end_c) begin
      cnt_d = '0;
      row_d = row_q + 3'd1;
      if (row_q == 3'd7) begin
        if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_d = '0;
          blink_d = ~blink_q;
        end else begin
          frame_d = frame_q + FRM_W'(1);
        end
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Leading part of each slot stays dark so the previous row cannot ghost.
    if (cnt_q >= CNT_W'(BLANK_CYCLES)) begin
      row_sel_d  = ~(8'h01 << row_q);
      col_data_d = pix_c;
    end
  end

  assign row_sel_o     = row_sel_q;
  assign col_data_o    = col_data_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_frogger_matrix_scan.sv
// Self-checking bench for frogger_matrix_scan: vector table, corner sequences,
// and randomized inputs against a cycle-index based reference model.
module tb_frogger_matrix_scan;

  localparam int D     = 8;
  localparam int BL    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 8 * D;

  typedef struct packed {
    logic [63:0] rows;
    logic [2:0]  fr;
    logic [7:0]  fc;
    logic        dead;
    logic        win;
  } in_t;

  typedef struct {
    in_t         in;
    logic [63:0] on;
    logic [63:0] off;
  } vec_t;

  logic       clk;
  logic       rst_ni;
  logic [7:0] row_sel_o;
  logic [7:0] col_data_o;
  logic       frame_start_o;

  in_t  cur;
  in_t  snap;
  int   n;
  int   compared;
  int   failed;
  vec_t vecs[5];

  frogger_matrix_scan #(
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(BL),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rows_i       (cur.rows),
    .frog_row_i   (cur.fr),
    .frog_col_i   (cur.fc),
    .dead_i       (cur.dead),
    .win_i        (cur.win),
    .row_sel_o    (row_sel_o),
    .col_data_o   (col_data_o),
    .frame_start_o(frame_start_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {row_sel, col_data, frame_start} for cycle n after reset release.
  function automatic logic [16:0] model(input int cyc, input in_t s);
    int         row, cnt, frame;
    bit         blink;
    logic [7:0] rs, cd;
    row   = (cyc / D) % 8;
    cnt   = cyc % D;
    frame = cyc / FRAME;
    blink = ((frame / BF) % 2) == 0;
    rs    = 8'hFF;
    cd    = 8'h00;
    if (cnt >= BL) begin
      rs = ~(8'h01 << row);
      if (s.dead && !blink)            cd = 8'hFF;
      else if (s.win && row == 0)      cd = 8'hFF;
      else begin
        cd = s.rows[row*8 +: 8];
        if (int'(s.fr) == row && blink) cd = cd | s.fc;
      end
    end
    return {rs, cd, (cyc % FRAME) == 0};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %02h expected %02h", name, n, act, exp);
    end
  endtask

  task automatic tick();
    logic [16:0] e;
    @(posedge clk);
    #1;
    n++;
    if (n % FRAME == 0) snap = cur;
    e = model(n, snap);
    check("row_sel", row_sel_o, e[16:9]);
    check("col_data", col_data_o, e[8:1]);
    check("frame_start", {7'd0, frame_start_o}, {7'd0, e[0]});
  endtask

  task automatic to_frame_end();
    while (n % FRAME != FRAME - 1) tick();
  endtask

  task automatic hold_reset_checks(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_row_sel"}, row_sel_o, 8'hFF);
      check({tag, "_col_data"}, col_data_o, 8'h00);
      check({tag, "_frame_start"}, {7'd0, frame_start_o}, 8'h00);
    end
  endtask

  initial begin
    logic [63:0] exp_row;
    int          k;
    compared = 0;
    failed   = 0;
    n        = -1;

    vecs[0] = '{in: '{64'h00000000_CC00EE00, 3'd7, 8'h10, 1'b0, 1'b0},
                on: 64'h10000000_CC00EE00, off: 64'h00000000_CC00EE00};
    vecs[1] = '{in: '{64'h00000000_CC00EE00, 3'd7, 8'h10, 1'b1, 1'b0},
                on: 64'h10000000_CC00EE00, off: 64'hFFFFFFFF_FFFFFFFF};
    vecs[2] = '{in: '{64'h00000000_CC00EE00, 3'd0, 8'h80, 1'b0, 1'b1},
                on: 64'h00000000_CC00EEFF, off: 64'h00000000_CC00EEFF};
    vecs[3] = '{in: '{64'h01234567_89ABCDEF, 3'd3, 8'h05, 1'b0, 1'b0},
                on: 64'h01234567_8DABCDEF, off: 64'h01234567_89ABCDEF};
    vecs[4] = '{in: '{64'h00000000_00000000, 3'd0, 8'h01, 1'b1, 1'b1},
                on: 64'h00000000_000000FF, off: 64'hFFFFFFFF_FFFFFFFF};

    cur    = '{64'h00000000_CC00EE00, 3'd7, 8'h10, 1'b0, 1'b0};
    snap   = '0;
    rst_ni = 1'b0;
    hold_reset_checks("reset");
    rst_ni = 1'b1;

    tick();
    check("first_frame_start", {7'd0, frame_start_o}, 8'h01);
    check("first_blank", row_sel_o, 8'hFF);
    tick();
    tick();
    check("first_drive_row0", row_sel_o, 8'hFE);
    while (n < 10) tick();
    check("first_drive_row1", row_sel_o, 8'hFD);
    check("first_drive_row1_col", col_data_o, 8'hEE);
    to_frame_end();

    // Table vectors over a whole blink period.
    for (int v = 0; v < 5; v++) begin
      cur = vecs[v].in;
      to_frame_end();
      for (int c = 0; c < 4 * FRAME; c++) begin
        tick();
        if (n % D >= BL) begin
          exp_row = (((n / FRAME) / BF) % 2 == 0) ? vecs[v].on : vecs[v].off;
          check($sformatf("vec%0d_col", v), col_data_o, exp_row[((n / D) % 8) * 8 +: 8]);
        end
      end
    end

    // Mid-frame change of row 3 must not appear until the next frame.
    cur = vecs[0].in;
    to_frame_end();
    tick();
    while (n % FRAME != 2 * D) tick();
    cur.rows[31:24] = 8'h33;
    while (n % FRAME != 3 * D + BL) tick();
    check("midframe_old", col_data_o, 8'hCC);
    to_frame_end();
    tick();
    while (n % FRAME != 3 * D + BL) tick();
    check("midframe_new", col_data_o, 8'h33);

    // Randomized inputs, changed at a random point inside each frame.
    for (int f = 0; f < 25; f++) begin
      k = $urandom_range(0, FRAME - 1);
      for (int c = 0; c < FRAME; c++) begin
        if (c == k) begin
          cur.rows = {$urandom, $urandom};
          cur.fr   = 3'($urandom_range(0, 7));
          cur.fc   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
          cur.dead = ($urandom_range(0, 3) == 0);
          cur.win  = ($urandom_range(0, 3) == 0);
        end
        tick();
      end
    end

    // Asynchronous reset in a row-5 drive cycle, then restart at row 0.
    cur = '{64'h00AA0000_00000000, 3'd2, 8'h04, 1'b0, 1'b0};
    to_frame_end();
    tick();
    while (n % FRAME != 5 * D + BL + 1) tick();
    check("pre_reset_row5", row_sel_o, 8'hDF);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_row_sel", row_sel_o, 8'hFF);
    check("async_col_data", col_data_o, 8'h00);
    check("async_frame_start", {7'd0, frame_start_o}, 8'h00);
    hold_reset_checks("midreset");
    rst_ni = 1'b1;
    n      = -1;
    tick();
    check("restart_frame_start", {7'd0, frame_start_o}, 8'h01);
    for (int c = 0; c < FRAME + D; c++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
